// File: rtl/equilibrio_pkg.sv
// Shared definitions for the balance-game step generator: FSM encoding,
// LFSR feedback taps and the default LFSR seed.
package equilibrio_pkg;

  typedef enum logic [1:0] {
    PARADO  = 2'd0,
    ATIVO   = 2'd1,
    TRAVADO = 2'd2
  } estado_t;

  // Feedback taps for x^8+x^6+x^5+x^4+1, shift-left form: q7, q5, q4, q3
  localparam logic [7:0] LFSR_TAPS        = 8'b1011_1000;
  localparam logic [7:0] LFSR_SEED_PADRAO = 8'hA5;
  // Bit of the LFSR state that gives the drift direction (1 = up)
  localparam logic [7:0] LFSR_BIT_DIRECAO = 8'h01;

  // Next LFSR state: shift left, new bit0 is the XOR of the tapped bits
  function automatic logic [7:0] lfsr_proximo(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by 8'h01
  function automatic logic [7:0] lfsr_semente(input logic [7:0] seed);
    return (seed == 8'h00) ? 8'h01 : seed;
  endfunction

endpackage

// File: rtl/lfsr_8.sv
// 8-bit Fibonacci LFSR with load-on-reset seed and an advance enable.
// Kept generic so other game logic can reuse it for randomness.
module lfsr_8
  import equilibrio_pkg::*;
(
  input  logic       clock,
  input  logic       zera_s,
  input  logic       avanca,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  // State register: reload seed on reset, otherwise step when asked
  always_ff @(posedge clock) begin
    if (zera_s) begin
      q <= lfsr_semente(seed);
    end else if (avanca) begin
      q <= lfsr_proximo(q);
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/gerador_passos_equilibrio.sv
// Step generator feeding the balance-position counter. Merges the player
// buttons with a pseudo-random drift and emits at most one step per game
// tick; stops stepping once the counter reports either end of its range.
module gerador_passos_equilibrio
  import equilibrio_pkg::*;
#(
  parameter int         DIV_TICK    = 50000,
  parameter int         DRIFT_EVERY = 4,
  parameter logic [7:0] LFSR_SEED   = LFSR_SEED_PADRAO
) (
  input  logic clock,
  input  logic zera_s,
  input  logic habilita,
  input  logic botao_esq,
  input  logic botao_dir,
  input  logic fim,
  input  logic inicio,
  output logic conta,
  output logic count_up,
  output logic tick,
  output logic travado
);

  localparam int              PW        = $clog2(DIV_TICK);
  localparam int              DW        = (DRIFT_EVERY > 1) ? $clog2(DRIFT_EVERY) : 1;
  localparam logic [PW-1:0]   PRE_MAX   = PW'(DIV_TICK - 1);
  localparam logic [DW-1:0]   DRIFT_MAX = DW'(DRIFT_EVERY - 1);

  estado_t       estado;
  estado_t       estado_prox;
  logic [PW-1:0] pre_cnt;
  logic [DW-1:0] drift_cnt;
  logic [7:0]    lfsr_q;

  logic segue_ativo;
  logic ativo_ok;
  logic tick_ok;
  logic drift_req;
  logic drift_up;
  logic player_req;
  logic player_up;
  logic passo_valido;
  logic passo_dir;

  lfsr_8 u_lfsr (
    .clock  (clock),
    .zera_s (zera_s),
    .avanca (tick_ok),
    .seed   (LFSR_SEED),
    .q      (lfsr_q)
  );

  // FSM state register
  always_ff @(posedge clock) begin
    if (zera_s) begin
      estado <= PARADO;
    end else begin
      estado <= estado_prox;
    end
  end

  // FSM next-state logic; habilita drop wins over the range flags
  always_comb begin
    estado_prox = estado;
    case (estado)
      PARADO: begin
        if (habilita) estado_prox = ATIVO;
        else          estado_prox = PARADO;
      end
      ATIVO: begin
        if (!habilita)          estado_prox = PARADO;
        else if (fim || inicio) estado_prox = TRAVADO;
        else                    estado_prox = ATIVO;
      end
      TRAVADO: begin
        if (!habilita) estado_prox = PARADO;
        else           estado_prox = TRAVADO;
      end
      default: estado_prox = PARADO;
    endcase
  end

  // FSM output logic: per-tick drift/player resolution into one step
  always_comb begin
    segue_ativo  = (estado == ATIVO) && (estado_prox == ATIVO);
    ativo_ok     = (estado == ATIVO) && habilita;
    tick_ok      = tick && ativo_ok;
    drift_req    = tick_ok && (drift_cnt == DRIFT_MAX);
    drift_up     = |(lfsr_q & LFSR_BIT_DIRECAO);
    player_req   = botao_esq ^ botao_dir;
    player_up    = botao_dir;
    passo_valido = 1'b0;
    passo_dir    = 1'b0;
    if (!tick_ok) begin
      passo_valido = 1'b0;
    end else if (player_req && drift_req) begin
      // Opposing requests cancel; agreeing ones collapse to one step
      passo_valido = (player_up == drift_up);
      passo_dir    = player_up;
    end else if (player_req) begin
      passo_valido = 1'b1;
      passo_dir    = player_up;
    end else if (drift_req) begin
      passo_valido = 1'b1;
      passo_dir    = drift_up;
    end else begin
      passo_valido = 1'b0;
    end
  end

  // Prescaler and registered tick; held at 0 unless staying in ATIVO
  always_ff @(posedge clock) begin
    if (zera_s) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else if (segue_ativo) begin
      pre_cnt <= (pre_cnt == PRE_MAX) ? '0 : pre_cnt + PW'(1);
      tick    <= (pre_cnt == PRE_MAX);
    end else begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end
  end

  // Drift counter: advances per tick, cleared whenever not running
  always_ff @(posedge clock) begin
    if (zera_s) begin
      drift_cnt <= '0;
    end else if (!ativo_ok) begin
      drift_cnt <= '0;
    end else if (tick_ok) begin
      drift_cnt <= (drift_cnt == DRIFT_MAX) ? '0 : drift_cnt + DW'(1);
    end else begin
      drift_cnt <= drift_cnt;
    end
  end

  // Registered step pulse; direction holds between pulses
  always_ff @(posedge clock) begin
    if (zera_s) begin
      conta    <= 1'b0;
      count_up <= 1'b0;
    end else if (passo_valido) begin
      conta    <= 1'b1;
      count_up <= passo_dir;
    end else begin
      conta    <= 1'b0;
      count_up <= count_up;
    end
  end

  // Lock-out indicator tracks the TRAVADO state
  always_ff @(posedge clock) begin
    if (zera_s) begin
      travado <= 1'b0;
    end else begin
      travado <= (estado_prox == TRAVADO);
    end
  end

endmodule

// File: tb/tb_gerador_passos_equilibrio.sv
// Directed bench for gerador_passos_equilibrio with DIV_TICK=4,
// DRIFT_EVERY=2, LFSR_SEED=8'hA5. LFSR states from the seed:
// A5,4A,95,2A,54,A9,53,A7,4E,9D,3B,77,EE; drift on every 2nd tick uses
// bit0 of the state seen at that tick.
module tb_gerador_passos_equilibrio;

  logic clock = 1'b0;
  logic zera_s, habilita, botao_esq, botao_dir, fim, inicio;
  logic conta, count_up, tick, travado;

  int checks = 0;
  int passes = 0;

  typedef struct {
    string nome;
    logic  esq;
    logic  dir;
    logic  exp_conta;
    logic  exp_up;
  } vec_t;

  vec_t tabela [11];

  gerador_passos_equilibrio #(
    .DIV_TICK    (4),
    .DRIFT_EVERY (2),
    .LFSR_SEED   (8'hA5)
  ) dut (
    .clock     (clock),
    .zera_s    (zera_s),
    .habilita  (habilita),
    .botao_esq (botao_esq),
    .botao_dir (botao_dir),
    .fim       (fim),
    .inicio    (inicio),
    .conta     (conta),
    .count_up  (count_up),
    .tick      (tick),
    .travado   (travado)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nome, input logic got, input logic exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %0b expected %0b", nome, got, exp);
    else passes++;
  endtask

  task automatic chk_int(input string nome, input int got, input int exp);
    checks++;
    if (got != exp) $display("FAIL %s: got %0d expected %0d", nome, got, exp);
    else passes++;
  endtask

  // Step until tick is seen (bounded); conta must stay low meanwhile
  task automatic wait_tick(input string nome, input int exp_n);
    int n;
    logic achou;
    n = 0;
    achou = 1'b0;
    while (n < 12 && !achou) begin
      step();
      n++;
      if (tick) achou = 1'b1;
      else chk({nome, "_conta_entre_ticks"}, conta, 1'b0);
    end
    chk({nome, "_tick_visto"}, achou, 1'b1);
    if (exp_n > 0) chk_int({nome, "_periodo_tick"}, n, exp_n);
  endtask

  task automatic run_tick(input string nome, input logic esq, input logic dir,
                          input logic exp_c, input logic exp_u, input int exp_n);
    botao_esq = esq;
    botao_dir = dir;
    wait_tick(nome, exp_n);
    step();
    chk({nome, "_conta"}, conta, exp_c);
    chk({nome, "_count_up"}, count_up, exp_u);
  endtask

  initial begin
    tabela[0]  = '{"t1_nada",        1'b0, 1'b0, 1'b0, 1'b0};
    tabela[1]  = '{"t2_drift_desce", 1'b0, 1'b0, 1'b1, 1'b0};
    tabela[2]  = '{"t3_dir",         1'b0, 1'b1, 1'b1, 1'b1};
    tabela[3]  = '{"t4_esq_drift_ig",1'b1, 1'b0, 1'b1, 1'b0};
    tabela[4]  = '{"t5_ambos",       1'b1, 1'b1, 1'b0, 1'b0};
    tabela[5]  = '{"t6_dir_drift_ig",1'b0, 1'b1, 1'b1, 1'b1};
    tabela[6]  = '{"t7_esq",         1'b1, 1'b0, 1'b1, 1'b0};
    tabela[7]  = '{"t8_esq_cancela", 1'b1, 1'b0, 1'b0, 1'b0};
    tabela[8]  = '{"t9_dir",         1'b0, 1'b1, 1'b1, 1'b1};
    tabela[9]  = '{"t10_drift_sobe", 1'b0, 1'b0, 1'b1, 1'b1};
    tabela[10] = '{"t11_ambos",      1'b1, 1'b1, 1'b0, 1'b1};

    zera_s = 1'b1; habilita = 1'b0; botao_esq = 1'b0; botao_dir = 1'b0;
    fim = 1'b0; inicio = 1'b0;
    step();
    step();
    chk("reset_conta", conta, 1'b0);
    chk("reset_count_up", count_up, 1'b0);
    chk("reset_tick", tick, 1'b0);
    chk("reset_travado", travado, 1'b0);
    chk_int("reset_lfsr", int'(dut.u_lfsr.q), 32'hA5);

    // Main table: one record per game tick
    zera_s = 1'b0;
    habilita = 1'b1;
    for (int i = 0; i < 11; i++) begin
      run_tick(tabela[i].nome, tabela[i].esq, tabela[i].dir,
               tabela[i].exp_conta, tabela[i].exp_up, (i == 0) ? 5 : 3);
    end

    // inicio pulse locks the generator; buttons are then ignored
    botao_esq = 1'b0; botao_dir = 1'b0;
    inicio = 1'b1;
    step();
    chk("trava_travado", travado, 1'b1);
    chk("trava_conta", conta, 1'b0);
    inicio = 1'b0;
    botao_dir = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("travado_conta", conta, 1'b0);
      chk("travado_tick", tick, 1'b0);
      chk("travado_alto", travado, 1'b1);
    end
    habilita = 1'b0;
    step();
    chk("destrava_travado", travado, 1'b0);
    habilita = 1'b1;
    run_tick("retoma_t1", 1'b0, 1'b1, 1'b1, 1'b1, 5);

    // fim in the tick cycle: the step being registered still issues
    botao_esq = 1'b1; botao_dir = 1'b0;
    wait_tick("fim_no_tick", 3);
    fim = 1'b1;
    step();
    chk("fim_no_tick_conta", conta, 1'b1);
    chk("fim_no_tick_count_up", count_up, 1'b0);
    chk("fim_no_tick_travado", travado, 1'b1);
    fim = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pos_fim_conta", conta, 1'b0);
      chk("pos_fim_travado", travado, 1'b1);
    end

    // zera_s in the tick cycle kills the pending step and reloads the seed
    habilita = 1'b0;
    botao_esq = 1'b0;
    step();
    habilita = 1'b1;
    wait_tick("zera_no_tick", 5);
    botao_dir = 1'b1;
    zera_s = 1'b1;
    step();
    chk("zera_conta", conta, 1'b0);
    chk("zera_count_up", count_up, 1'b0);
    chk("zera_tick", tick, 1'b0);
    chk("zera_travado", travado, 1'b0);
    chk_int("zera_lfsr", int'(dut.u_lfsr.q), 32'hA5);
    zera_s = 1'b0;
    run_tick("pos_zera_t1", 1'b0, 1'b0, 1'b0, 1'b0, 5);
    run_tick("pos_zera_t2", 1'b0, 1'b0, 1'b1, 1'b0, 3);

    // habilita drop in the prescaler's last cycle: no tick, no step
    step();
    step();
    habilita = 1'b0;
    step();
    chk("queda_tick", tick, 1'b0);
    chk("queda_conta", conta, 1'b0);
    chk("queda_travado", travado, 1'b0);
    step();
    chk("queda_conta2", conta, 1'b0);
    chk("queda_tick2", tick, 1'b0);

    // Press released before the tick is not remembered
    habilita = 1'b1;
    botao_dir = 1'b1;
    step();
    step();
    botao_dir = 1'b0;
    wait_tick("botao_fora_tick", 3);
    step();
    chk("botao_fora_tick_conta", conta, 1'b0);

    // habilita drop in the tick cycle suppresses an agreeing step
    botao_esq = 1'b1;
    wait_tick("queda_no_tick", 3);
    habilita = 1'b0;
    step();
    chk("queda_no_tick_conta", conta, 1'b0);
    chk("queda_no_tick_travado", travado, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
